// File: rtl/fifo_uart_tx_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter.
//   - FSM state encoding (binary, 3 bits)
//   - parity type codes
//   - serial line levels
package fifo_uart_tx_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_START  = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_PARITY = 3'd4;
  localparam logic [2:0] ST_STOP   = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_LOAD   = ST_LOAD,
    S_START  = ST_START,
    S_DATA   = ST_DATA,
    S_PARITY = ST_PARITY,
    S_STOP   = ST_STOP
  } tx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/fifo_uart_tx_serializer.sv
// uart_tx_serializer: payload shift register, bit counter and parity.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   load         capture data (clears counter, latches data parity)
//   shift        shift right one place, advance bit counter
//   data         word to serialize
//   ser_bit      bit 0 of the register as it will be after this cycle
//                (feeds the registered line driver in the top)
//   last_bit     counter is at DATA_WIDTH-1
//   parity_bit   XOR of the captured word
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  shift,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  ser_bit,
  output logic                  last_bit,
  output logic                  parity_bit
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  par_q, par_d;

  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    par_d = par_q;
    if (load) begin
      sh_d  = data;
      cnt_d = '0;
      par_d = ^data;
    end else if (shift) begin
      sh_d  = {1'b0, sh_q[DATA_WIDTH-1:1]};
      cnt_d = last_bit ? '0 : cnt_q + CW'(1);
    end
  end

  // Look-ahead bit: the top registers the line, so it needs the bit that
  // will sit at position 0 during the next cycle.
  assign ser_bit    = sh_d[0];
  assign last_bit   = (cnt_q == CW'(DATA_WIDTH - 1));
  assign parity_bit = par_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q  <= '0;
      cnt_q <= '0;
      par_q <= 1'b0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
      par_q <= par_d;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from the TX FIFO read side and sends each as an
// 8N1 / 8E1 / 8O1 frame, one bit per CLK cycle.
// Ports:
//   CLK, RST       UART bit clock, async active-low reset
//   FIFO_RD_DATA   word at the FIFO read pointer
//   FIFO_EMPTY     FIFO empty flag (CLK domain)
//   PAR_EN/PAR_TYP parity enable / type (0 even, 1 odd), latched at LOAD
//   FIFO_RD_INC    one-cycle pop strobe, high only in LOAD
//   TX_OUT         serial line, idles high
//   BUSY           high from LOAD through STOP
// All outputs come straight from flops whose D inputs are decoded from the
// next state, so they line up with the state register and cannot glitch.
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] FIFO_RD_DATA,
  input  logic                  FIFO_EMPTY,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  FIFO_RD_INC,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  tx_state_e state_q, state_d;
  logic      par_en_q, par_en_d;
  logic      par_typ_q, par_typ_d;
  logic      tx_q, tx_d;
  logic      busy_q, busy_d;
  logic      rd_inc_q, rd_inc_d;

  logic      load, shift;
  logic      ser_bit, last_bit, parity_bit;

  assign load  = (state_q == S_LOAD);
  assign shift = (state_q == S_DATA);

  uart_tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
    .clk        (CLK),
    .rst_n      (RST),
    .load       (load),
    .shift      (shift),
    .data       (FIFO_RD_DATA),
    .ser_bit    (ser_bit),
    .last_bit   (last_bit),
    .parity_bit (parity_bit)
  );

  always_comb begin
    state_d   = state_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    tx_d      = IDLE_LEVEL;

    case (state_q)
      S_IDLE:   if (!FIFO_EMPTY) state_d = S_LOAD;
      S_LOAD:   state_d = S_START;
      S_START:  state_d = S_DATA;
      S_DATA:   if (last_bit) state_d = par_en_q ? S_PARITY : S_STOP;
      S_PARITY: state_d = S_STOP;
      S_STOP:   state_d = FIFO_EMPTY ? S_IDLE : S_LOAD;
      default:  state_d = S_IDLE;
    endcase

    if (load) begin
      par_en_d  = PAR_EN;
      par_typ_d = PAR_TYP;
    end

    // Line level for the cycle we are about to enter.
    case (state_d)
      S_START:  tx_d = START_LEVEL;
      S_DATA:   tx_d = ser_bit;
      S_PARITY: tx_d = parity_bit ^ (par_typ_q == PAR_ODD);
      default:  tx_d = IDLE_LEVEL;
    endcase

    busy_d   = (state_d != S_IDLE);
    rd_inc_d = (state_d == S_LOAD);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      tx_q      <= IDLE_LEVEL;
      busy_q    <= 1'b0;
      rd_inc_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      rd_inc_q  <= rd_inc_d;
    end
  end

  assign TX_OUT      = tx_q;
  assign BUSY        = busy_q;
  assign FIFO_RD_INC = rd_inc_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with a small queue-based FIFO model.
module tb_fifo_uart_tx;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] FIFO_RD_DATA = 8'h00;
  logic       FIFO_EMPTY = 1'b1;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       FIFO_RD_INC;
  logic       TX_OUT;
  logic       BUSY;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         rd_cnt = 0;
  bit         pop_pend = 1'b0;
  logic [7:0] fq[$];

  fifo_uart_tx #(.DATA_WIDTH(8)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .FIFO_RD_DATA (FIFO_RD_DATA),
    .FIFO_EMPTY   (FIFO_EMPTY),
    .PAR_EN       (PAR_EN),
    .PAR_TYP      (PAR_TYP),
    .FIFO_RD_INC  (FIFO_RD_INC),
    .TX_OUT       (TX_OUT),
    .BUSY         (BUSY)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic refresh();
    FIFO_EMPTY   = (fq.size() == 0);
    FIFO_RD_DATA = (fq.size() != 0) ? fq[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
    refresh();
  endtask

  // One cycle: pop just after the edge that closes a LOAD cycle, then land
  // on the falling edge and sample the DUT.
  task automatic step();
    @(posedge CLK);
    #1;
    if (pop_pend) begin
      if (fq.size() != 0) void'(fq.pop_front());
      pop_pend = 1'b0;
    end
    refresh();
    @(negedge CLK);
    cyc++;
    pop_pend = FIFO_RD_INC;
    if (FIFO_RD_INC) rd_cnt++;
  endtask

  task automatic wait_load(input string tag, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!FIFO_RD_INC && n < 20);
    chk({tag, "_load_seen"}, FIFO_RD_INC, 1);
  endtask

  // Entered on the falling edge of the LOAD cycle; leaves on the falling
  // edge of the STOP cycle.
  task automatic frame(input string tag, input logic [7:0] data, input bit pen,
                       input logic par_exp, input bit flip);
    logic [7:0] d;
    d = data;
    chk({tag, "_load_tx"}, TX_OUT, 1);
    chk({tag, "_load_busy"}, BUSY, 1);
    step();
    chk({tag, "_start"}, TX_OUT, 0);
    chk({tag, "_start_inc"}, FIFO_RD_INC, 0);
    for (int i = 0; i < 8; i++) begin
      step();
      if (flip && i == 3) PAR_TYP = ~PAR_TYP;
      chk($sformatf("%s_data%0d", tag, i), TX_OUT, d[i]);
      chk($sformatf("%s_busy%0d", tag, i), BUSY, 1);
    end
    if (pen) begin
      step();
      chk({tag, "_parity"}, TX_OUT, par_exp);
    end
    step();
    chk({tag, "_stop"}, TX_OUT, 1);
    chk({tag, "_stop_busy"}, BUSY, 1);
  endtask

  initial begin
    int n, c0, r0, errs;
    logic [9:0] a5_line;
    refresh();

    // Reset state.
    step();
    step();
    chk("rst_tx", TX_OUT, 1);
    chk("rst_busy", BUSY, 0);
    chk("rst_inc", FIFO_RD_INC, 0);
    RST = 1'b1;
    repeat (3) step();
    chk("idle_tx", TX_OUT, 1);
    chk("idle_busy", BUSY, 0);

    // 0xA5, no parity: expected line 0,1,0,1,0,0,1,0,1,1 (start..stop).
    a5_line = 10'b11_0100_1010; // bit 0 = start bit
    push(8'hA5);
    wait_load("a5", n);
    chk("a5_latency", n, 1);
    chk("a5_load_tx", TX_OUT, 1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("a5_line%0d", i), TX_OUT, a5_line[i]);
      chk($sformatf("a5_busy%0d", i), BUSY, 1);
    end
    step();
    chk("a5_after_busy", BUSY, 0);
    chk("a5_after_tx", TX_OUT, 1);
    chk("a5_pops", rd_cnt, 1);

    // Parity cases.
    PAR_EN = 1'b1; PAR_TYP = 1'b0;
    push(8'h03);
    wait_load("p03e", n);
    frame("p03e", 8'h03, 1, 1'b0, 0);
    PAR_TYP = 1'b1;
    push(8'h07);
    wait_load("p07o", n);
    frame("p07o", 8'h07, 1, 1'b0, 0);
    PAR_TYP = 1'b0;
    push(8'h07);
    wait_load("p07e", n);
    frame("p07e", 8'h07, 1, 1'b1, 0);
    step();
    chk("par_idle_busy", BUSY, 0);

    // Back-to-back, no parity.
    PAR_EN = 1'b0;
    r0 = rd_cnt;
    push(8'h11); push(8'h22); push(8'h33);
    wait_load("b2b", n);
    c0 = cyc;
    frame("b11", 8'h11, 0, 1'b0, 0);
    step();
    chk("b2b_load2", FIFO_RD_INC, 1);
    chk("b2b_gap2", cyc - c0, 11);
    c0 = cyc;
    frame("b22", 8'h22, 0, 1'b0, 0);
    step();
    chk("b2b_load3", FIFO_RD_INC, 1);
    chk("b2b_gap3", cyc - c0, 11);
    frame("b33", 8'h33, 0, 1'b0, 0);
    step();
    chk("b2b_end_busy", BUSY, 0);
    chk("b2b_end_inc", FIFO_RD_INC, 0);
    chk("b2b_pops", rd_cnt - r0, 3);
    chk("b2b_empty", FIFO_EMPTY, 1);

    // Empty for 50 cycles.
    errs = 0;
    repeat (50) begin
      step();
      if (FIFO_RD_INC !== 1'b0 || TX_OUT !== 1'b1 || BUSY !== 1'b0) errs++;
    end
    chk("idle50", errs, 0);

    // Reset during data bit 4 of 0xFF.
    push(8'hFF);
    wait_load("rff", n);
    repeat (6) step();          // start + data bits 0..4
    chk("rff_bit4_busy", BUSY, 1);
    RST = 1'b0;
    #1;
    chk("rff_rst_tx", TX_OUT, 1);
    chk("rff_rst_busy", BUSY, 0);
    chk("rff_rst_inc", FIFO_RD_INC, 0);
    step();
    step();
    chk("rff_hold_busy", BUSY, 0);
    RST = 1'b1;
    push(8'h5A);
    wait_load("r5a", n);
    chk("r5a_latency", n, 1);
    frame("r5a", 8'h5A, 0, 1'b0, 0);

    // PAR_TYP flipped mid-frame: latched even parity still applies.
    PAR_EN = 1'b1; PAR_TYP = 1'b0;
    push(8'h01);
    wait_load("t01", n);
    frame("t01", 8'h01, 1, 1'b1, 1);
    step();
    chk("t01_idle_busy", BUSY, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Read-side consumer of the asynchronous TX FIFO. Runs in the UART TX clock domain, one serial bit per CLK cycle; the clock divider supplies CLK. Pops one byte whenever the FIFO is non-empty, then sends it as an 8N1 or 8E1/8O1 UART frame on TX_OUT. Drives the FIFO's read-increment input and observes its EMPTY and read-data outputs directly.

## Interface
- DATA_WIDTH, 8, width of FIFO read data and of the serialized payload
- CLK  in  1  UART TX clock; one bit period per cycle
- RST  in  1  asynchronous, active-low reset
- FIFO_RD_DATA  in  DATA_WIDTH  FIFO registered read data; holds the word at the current read pointer
- FIFO_EMPTY  in  1  FIFO empty flag, already in the CLK domain
- PAR_EN  in  1  1 = append a parity bit
- PAR_TYP  in  1  0 = even parity, 1 = odd parity
- FIFO_RD_INC  out  1  one-cycle pop strobe to the FIFO read-increment input
- TX_OUT  out  1  serial line; idles high
- BUSY  out  1  high while a frame is being loaded or sent

One clock; reset is asynchronous and active-low (ports CLK and RST).

## Operation
- States: IDLE, LOAD, START, DATA, PARITY, STOP.
- IDLE: TX_OUT=1, BUSY=0. If FIFO_EMPTY=0, go to LOAD. Otherwise stay in IDLE.
- LOAD, one cycle:
  - FIFO_RD_INC=1, BUSY=1, TX_OUT=1.
  - At the closing edge, capture FIFO_RD_DATA into the shift register, and PAR_EN/PAR_TYP into config registers.
  - Next state is START.
- START, one cycle: TX_OUT=0.
- DATA, DATA_WIDTH cycles: TX_OUT = shift register bit 0; shift right each cycle, LSB first. A bit counter of width clog2(DATA_WIDTH) runs 0..DATA_WIDTH-1. At the last count, go to PARITY if latched PAR_EN=1, else STOP.
- PARITY, one cycle:
  - TX_OUT = XOR of captured byte XOR latched PAR_TYP.
  - Even parity gives an even count of ones over data plus parity bit.
- STOP, one cycle: TX_OUT=1. Next state is LOAD if FIFO_EMPTY=0 (back-to-back frames), else IDLE.
- FIFO_EMPTY is sampled only in IDLE and STOP.
- PAR_EN/PAR_TYP changes mid-frame have no effect until the next LOAD.
- FIFO_RD_INC is asserted exactly once per frame, never while FIFO_EMPTY=1, and never in any state other than LOAD.

## Timing
- Reset (asynchronous, immediate): state=IDLE, TX_OUT=1, BUSY=0, FIFO_RD_INC=0, shift register=0, counter=0, config registers=0.
- Reset mid-frame aborts the frame: line returns high at once; the byte already popped is lost.
- Latency: FIFO_EMPTY low at edge k → LOAD during cycle k+1 → start bit during cycle k+2.
- Line frame length: 10 cycles (PAR_EN=0) or 11 cycles (PAR_EN=1).
- Back-to-back period: 11 or 12 cycles; the LOAD cycle adds one idle-high cycle between frames.
- All outputs are decoded from registered state/datapath only, with no combinational path from inputs to outputs. TX_OUT must be glitch-free.
- Integration constraints:
  - FIFO_RD_DATA must be valid for the word at the read pointer whenever FIFO_EMPTY=0 in the sampling cycle.
  - FIFO_EMPTY must reflect a pop within 9 CLK cycles of FIFO_RD_INC, which is the minimum gap to the next STOP sample.

## Structure
- Shared package contents:
  - state encoding localparams for IDLE/LOAD/START/DATA/PARITY/STOP, binary 3 bits
  - PAR_EVEN=0 and PAR_ODD=1
  - line levels IDLE_LEVEL=1, START_LEVEL=0
- Top module: FSM, config latching, FIFO handshake.
- One sub-module, uart_tx_serializer:
  - shift register, bit counter and parity XOR
  - inputs: load, shift, data
  - outputs: ser_bit, last_bit, parity_bit

## Test plan
- Single byte 0xA5, PAR_EN=0: after FIFO_EMPTY falls, one FIFO_RD_INC pulse; TX_OUT = 0,1,0,1,0,0,1,0,1,1 over 10 cycles; BUSY high for 11 cycles; then idle high.
- Even parity: byte 0x03 with PAR_EN=1, PAR_TYP=0 → parity bit 0. Odd parity: byte 0x07 with PAR_EN=1, PAR_TYP=1 → parity bit 0. Byte 0x07 with even parity → parity bit 1.
- Back-to-back bytes 0x11, 0x22, 0x33 preloaded: exactly 3 FIFO_RD_INC pulses, spaced 11 cycles apart with PAR_EN=0. Three correct frames, each preceded by one high LOAD cycle. Ends in IDLE with FIFO_EMPTY=1.
- FIFO_EMPTY held 1 for 50 cycles: FIFO_RD_INC never asserts; TX_OUT=1 and BUSY=0 throughout.
- RST asserted during DATA bit 4 of 0xFF: TX_OUT=1, BUSY=0 and FIFO_RD_INC=0 immediately. After release with FIFO_EMPTY=0, the next frame starts cleanly via LOAD.
- PAR_TYP toggled during DATA of 0x01 (PAR_EN=1, latched PAR_TYP=0): parity bit still 1, using the latched even setting.
